// File: rtl/block_dispatcher_pkg.sv
// Shared types and helpers for the thread-block dispatcher.
package dispatch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DONE,
        ST_ABORT
    } top_state_t;

    typedef enum logic [1:0] {
        CS_FREE,
        CS_BUSY,
        CS_RECYCLE
    } core_state_t;

    // Ceiling division by a power of two, given as its log2.
    function automatic logic [31:0] ceil_div(input logic [31:0] num, input int unsigned den_log2);
        logic [31:0] den;
        den = 32'(1) << den_log2;
        return (num + den - 32'(1)) >> den_log2;
    endfunction

    // Number of set bits in a vector of up to 32 bits.
    function automatic logic [31:0] popcount(input logic [31:0] v);
        logic [31:0] sum;
        sum = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            sum = sum + 32'(v[i]);
        end
        return sum;
    endfunction

endpackage

// File: rtl/block_dispatcher_if.sv
// Core-array bus between the dispatcher (master) and the compute cores (slave).
interface block_dispatcher_if #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned BID_W     = 16,
    parameter int unsigned TPB_W     = 3
);
    logic [NUM_CORES-1:0]       core_done;
    logic [NUM_CORES-1:0]       core_start;
    logic [NUM_CORES-1:0]       core_reset;
    logic [NUM_CORES*BID_W-1:0] core_block_id;
    logic [NUM_CORES*TPB_W-1:0] core_thread_count;

    modport master (
        input  core_done,
        output core_start,
        output core_reset,
        output core_block_id,
        output core_thread_count
    );

    modport slave (
        output core_done,
        input  core_start,
        input  core_reset,
        input  core_block_id,
        input  core_thread_count
    );
endinterface

// File: rtl/block_dispatcher_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter  int unsigned N  = 4,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          valid
);

    // Scan requesters starting at the pointer; only the first hit is granted.
    always_comb begin
        int unsigned idx;
        logic        found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = 32'(ptr) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[PW'(idx)]) begin
                grant[PW'(idx)] = 1'b1;
                found           = 1'b1;
            end
        end
        valid = found;
    end

endmodule

// File: rtl/block_dispatcher.sv
// Thread-block dispatcher: splits a kernel into blocks and issues them round-robin to the cores.
module block_dispatcher
    import dispatch_pkg::*;
#(
    parameter  int unsigned NUM_CORES         = 4,
    parameter  int unsigned THREADS_PER_BLOCK = 4,
    parameter  int unsigned TC_W              = 16,
    parameter  int unsigned BID_W             = 16,
    localparam int unsigned TPB_W             = $clog2(THREADS_PER_BLOCK) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic [TC_W-1:0]         thread_count,
    block_dispatcher_if.master      cores,
    output logic                    busy,
    output logic                    done,
    output logic [TC_W-1:0]         blocks_completed
);

    localparam int unsigned PW      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int unsigned TPB_LOG = $clog2(THREADS_PER_BLOCK);

    top_state_t         state;
    core_state_t        core_state [NUM_CORES];
    logic [TC_W-1:0]    tc_q;
    logic [TC_W:0]      total_q;
    logic [TC_W:0]      issued_q;
    logic [PW-1:0]      rr_ptr;

    logic [NUM_CORES-1:0] free_vec;
    logic [NUM_CORES-1:0] fin_vec;
    logic [NUM_CORES-1:0] grant;
    logic                 grant_valid;
    logic [PW-1:0]        grant_idx;
    logic [PW-1:0]        rr_next;
    logic [TC_W:0]        total_next;
    logic [TC_W:0]        done_sum;
    logic [TPB_W-1:0]     last_tc;
    logic [TPB_W-1:0]     issue_tc;

    rr_arbiter #(.N(NUM_CORES)) u_arb (
        .req   (free_vec),
        .ptr   (rr_ptr),
        .grant (grant),
        .valid (grant_valid)
    );

    // Per-core status vectors, completion sum, grant index and next issue parameters.
    always_comb begin
        free_vec = '0;
        fin_vec  = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            free_vec[i] = (core_state[i] == CS_FREE);
            fin_vec[i]  = (core_state[i] == CS_BUSY) && cores.core_done[i];
        end
        done_sum = {1'b0, blocks_completed} + (TC_W+1)'(popcount(32'(fin_vec)));

        grant_idx = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (grant[i]) begin
                grant_idx = PW'(i);
            end
        end
        rr_next = (grant_idx == PW'(NUM_CORES - 1)) ? '0 : grant_idx + PW'(1);

        total_next = (TC_W+1)'(ceil_div(32'(thread_count), TPB_LOG));
        last_tc    = TPB_W'({1'b0, tc_q} - ((total_q - (TC_W+1)'(1)) << TPB_LOG));
        issue_tc   = (issued_q == total_q - (TC_W+1)'(1)) ? last_tc : TPB_W'(THREADS_PER_BLOCK);
    end

    // Top FSM, per-core FSMs and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                   <= ST_IDLE;
            cores.core_start        <= '0;
            cores.core_reset        <= '1;
            cores.core_block_id     <= '0;
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
                cores.core_thread_count[i*TPB_W +: TPB_W] <= TPB_W'(THREADS_PER_BLOCK);
                core_state[i] <= CS_FREE;
            end
            busy             <= 1'b0;
            done             <= 1'b0;
            blocks_completed <= '0;
            rr_ptr           <= '0;
            tc_q             <= '0;
            total_q          <= '0;
            issued_q         <= '0;
        end else begin
            // A recycled core ends its reset pulse and becomes grantable next cycle.
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
                if (core_state[i] == CS_RECYCLE) begin
                    core_state[i]       <= CS_FREE;
                    cores.core_reset[i] <= 1'b0;
                end
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        tc_q             <= thread_count;
                        total_q          <= total_next;
                        issued_q         <= '0;
                        blocks_completed <= '0;
                        done             <= 1'b0;
                        busy             <= 1'b1;
                        cores.core_start <= '0;
                        cores.core_reset <= '1;
                        for (int unsigned i = 0; i < NUM_CORES; i++) begin
                            core_state[i] <= CS_FREE;
                        end
                        state <= ST_CLEAR;
                    end
                end

                ST_CLEAR: begin
                    if (abort) begin
                        cores.core_start <= '0;
                        cores.core_reset <= '1;
                        busy             <= 1'b0;
                        done             <= 1'b0;
                        for (int unsigned i = 0; i < NUM_CORES; i++) begin
                            core_state[i] <= CS_FREE;
                        end
                        state <= ST_ABORT;
                    end else if (total_q == '0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        state <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (abort) begin
                        cores.core_start <= '0;
                        cores.core_reset <= '1;
                        busy             <= 1'b0;
                        done             <= 1'b0;
                        for (int unsigned i = 0; i < NUM_CORES; i++) begin
                            core_state[i] <= CS_FREE;
                        end
                        state <= ST_ABORT;
                    end else begin
                        // Finished cores drop run enable and take a one-cycle reset pulse.
                        for (int unsigned i = 0; i < NUM_CORES; i++) begin
                            if (fin_vec[i]) begin
                                core_state[i]       <= CS_RECYCLE;
                                cores.core_start[i] <= 1'b0;
                                cores.core_reset[i] <= 1'b1;
                            end
                        end
                        blocks_completed <= done_sum[TC_W-1:0];

                        // Granted cores are always FREE, so they never collide with a finishing core.
                        if (grant_valid && (issued_q < total_q)) begin
                            for (int unsigned i = 0; i < NUM_CORES; i++) begin
                                if (grant[i]) begin
                                    core_state[i]       <= CS_BUSY;
                                    cores.core_start[i] <= 1'b1;
                                    cores.core_reset[i] <= 1'b0;
                                    cores.core_block_id[i*BID_W +: BID_W]     <= BID_W'(issued_q);
                                    cores.core_thread_count[i*TPB_W +: TPB_W] <= issue_tc;
                                end
                            end
                            issued_q <= issued_q + (TC_W+1)'(1);
                            rr_ptr   <= rr_next;
                        end

                        if (done_sum == total_q) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end

                ST_ABORT: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_block_dispatcher.sv
// Directed self-checking bench for block_dispatcher (4 cores, 4 threads per block).
module tb_block_dispatcher;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic [15:0] thread_count;
    logic        busy;
    logic        done;
    logic [15:0] blocks_completed;

    int unsigned n_total;
    int unsigned n_bad;

    block_dispatcher_if #(.NUM_CORES(4), .BID_W(16), .TPB_W(3)) bus ();

    block_dispatcher #(
        .NUM_CORES(4),
        .THREADS_PER_BLOCK(4),
        .TC_W(16),
        .BID_W(16)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .abort            (abort),
        .thread_count     (thread_count),
        .cores            (bus.master),
        .busy             (busy),
        .done             (done),
        .blocks_completed (blocks_completed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] bid(input int unsigned i);
        return bus.core_block_id[i*16 +: 16];
    endfunction

    function automatic logic [2:0] tcnt(input int unsigned i);
        return bus.core_thread_count[i*3 +: 3];
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic launch(input logic [15:0] tc);
        start        = 1'b1;
        thread_count = tc;
        tick();
        start = 1'b0;
    endtask

    initial begin
        n_total      = 0;
        n_bad        = 0;
        reset        = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        thread_count = '0;
        bus.core_done = '0;

        // Reset values
        tick();
        tick();
        check("rst_start", bus.core_start, 4'b0000);
        check("rst_creset", bus.core_reset, 4'b1111);
        check("rst_bid", bus.core_block_id, 64'h0);
        check("rst_tcnt", bus.core_thread_count, 12'h924);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_bc", blocks_completed, 16'd0);
        reset = 1'b1;

        // tc=10: blocks 0,1,2 on cores 0,1,2, last block has 2 threads
        launch(16'd10);
        check("a_busy", busy, 1'b1);
        check("a_clear_creset", bus.core_reset, 4'b1111);
        tick();
        check("a_clear_start", bus.core_start, 4'b0000);
        tick();
        check("a_g0_start", bus.core_start, 4'b0001);
        check("a_g0_creset", bus.core_reset, 4'b1110);
        check("a_g0_bid", bid(0), 16'd0);
        check("a_g0_tc", tcnt(0), 3'd4);
        tick();
        check("a_g1_start", bus.core_start, 4'b0011);
        check("a_g1_bid", bid(1), 16'd1);
        tick();
        check("a_g2_start", bus.core_start, 4'b0111);
        check("a_g2_bid", bid(2), 16'd2);
        check("a_g2_tc", tcnt(2), 3'd2);
        tick();
        check("a_nomore", bus.core_start, 4'b0111);
        check("a_bc0", blocks_completed, 16'd0);
        bus.core_done = 4'b0010;
        tick();
        bus.core_done = 4'b0000;
        check("a_c1_start", bus.core_start, 4'b0101);
        check("a_c1_creset", bus.core_reset, 4'b1010);
        check("a_c1_bc", blocks_completed, 16'd1);
        tick();
        check("a_pulse_end", bus.core_reset, 4'b1000);
        check("a_notdone", done, 1'b0);
        bus.core_done = 4'b0101;
        tick();
        check("a_fin_bc", blocks_completed, 16'd3);
        check("a_fin_done", done, 1'b1);
        check("a_fin_busy", busy, 1'b0);
        check("a_fin_start", bus.core_start, 4'b0000);
        bus.core_done = 4'b1111;
        tick();
        bus.core_done = 4'b0000;
        check("a_ign_bc", blocks_completed, 16'd3);
        check("a_ign_done", done, 1'b1);

        // tc=0: done two cycles after start, no core started
        do_reset();
        launch(16'd0);
        check("b_busy", busy, 1'b1);
        check("b_done0", done, 1'b0);
        tick();
        check("b_done", done, 1'b1);
        check("b_idle_busy", busy, 1'b0);
        check("b_bc", blocks_completed, 16'd0);
        tick();
        check("b_nostart", bus.core_start, 4'b0000);

        // tc=8: cores 0,1 only; pointer then points at core 2
        do_reset();
        launch(16'd8);
        tick();
        tick();
        check("c_g0", bus.core_start, 4'b0001);
        tick();
        check("c_g1", bus.core_start, 4'b0011);
        check("c_g1_bid", bid(1), 16'd1);
        check("c_g1_tc", tcnt(1), 3'd4);
        tick();
        check("c_only2", bus.core_start, 4'b0011);
        bus.core_done = 4'b0011;
        tick();
        bus.core_done = 4'b0000;
        check("c_bc", blocks_completed, 16'd2);
        check("c_done", done, 1'b1);
        tick();
        launch(16'd4);
        check("c2_done_clr", done, 1'b0);
        check("c2_bc_clr", blocks_completed, 16'd0);
        tick();
        tick();
        check("c2_rr_core2", bus.core_start, 4'b0100);
        check("c2_creset", bus.core_reset, 4'b1011);
        check("c2_bid", bid(2), 16'd0);
        check("c2_tc", tcnt(2), 3'd4);
        bus.core_done = 4'b0100;
        tick();
        bus.core_done = 4'b0000;
        check("c2_done", done, 1'b1);
        check("c2_bc", blocks_completed, 16'd1);

        // tc=16 from pointer 3: order 3,0,1,2; all four finish together
        launch(16'd16);
        tick();
        tick();
        check("d_g0", bus.core_start, 4'b1000);
        tick();
        check("d_g1", bus.core_start, 4'b1001);
        tick();
        tick();
        check("d_all", bus.core_start, 4'b1111);
        check("d_bid3", bid(3), 16'd0);
        check("d_bid0", bid(0), 16'd1);
        check("d_bid1", bid(1), 16'd2);
        check("d_bid2", bid(2), 16'd3);
        check("d_tc2", tcnt(2), 3'd4);
        check("d_bc0", blocks_completed, 16'd0);
        bus.core_done = 4'b1111;
        tick();
        bus.core_done = 4'b0000;
        check("d_bc4", blocks_completed, 16'd4);
        check("d_done", done, 1'b1);
        check("d_creset", bus.core_reset, 4'b1111);

        // Abort with two blocks in flight (cores 3 and 0)
        launch(16'd20);
        tick();
        tick();
        tick();
        check("e_inflight", bus.core_start, 4'b1001);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("e_ab_start", bus.core_start, 4'b0000);
        check("e_ab_creset", bus.core_reset, 4'b1111);
        check("e_ab_busy", busy, 1'b0);
        check("e_ab_done", done, 1'b0);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("e_idle_abort", busy, 1'b0);
        launch(16'd4);
        check("e_relaunch", busy, 1'b1);
        tick();
        tick();
        check("e2_core1", bus.core_start, 4'b0010);
        bus.core_done = 4'b0010;
        abort = 1'b1;
        tick();
        bus.core_done = 4'b0000;
        abort = 1'b0;
        check("e2_abwins_done", done, 1'b0);
        check("e2_abwins_bc", blocks_completed, 16'd0);
        check("e2_abwins_busy", busy, 1'b0);
        tick();

        // Asynchronous reset between edges, then clean relaunch
        launch(16'd8);
        tick();
        tick();
        check("f_core2", bus.core_start, 4'b0100);
        #2;
        reset = 1'b0;
        #1;
        check("f_ar_start", bus.core_start, 4'b0000);
        check("f_ar_creset", bus.core_reset, 4'b1111);
        check("f_ar_busy", busy, 1'b0);
        check("f_ar_bid", bus.core_block_id, 64'h0);
        check("f_ar_tcnt", bus.core_thread_count, 12'h924);
        tick();
        reset = 1'b1;
        launch(16'd5);
        tick();
        tick();
        check("f2_g0", bus.core_start, 4'b0001);
        tick();
        check("f2_g1", bus.core_start, 4'b0011);
        check("f2_tc1", tcnt(1), 3'd1);
        check("f2_bid1", bid(1), 16'd1);
        bus.core_done = 4'b0011;
        tick();
        bus.core_done = 4'b0000;
        check("f2_bc", blocks_completed, 16'd2);
        check("f2_done", done, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
